// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and anode helpers for the scanned
// 7-segment display capture block.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment patterns {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seg7_state_e;

  // An anode word selects a digit only when exactly one bit is low.
  function automatic logic an_is_legal(input logic [7:0] an);
    logic [3:0] zeros;
    zeros = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zeros = zeros + {3'd0, ~an[i]};
    end
    return (zeros == 4'd1);
  endfunction

  function automatic logic [2:0] an_position(input logic [7:0] an);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pos = an[i] ? pos : 3'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a 7-segment pattern into a hex nibble with
// hex / blank classification; anything else is an unrecognised pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  // Table search; the 16 patterns are distinct so at most one matches
  always_comb begin
    nibble   = 4'd0;
    is_hex   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nibble = (pattern == SEG_HEX[i]) ? 4'(i) : nibble;
      is_hex = (pattern == SEG_HEX[i]) ? 1'b1 : is_hex;
    end
    is_blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 8-digit anode/segment bus, settles each dwell,
// and publishes the reconstructed hex word once per complete scan frame.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic [6:0]  SEG,
  output logic [31:0] HEX,
  output logic        FRAME_VALID,
  output logic [7:0]  DIGIT_ERR,
  output logic [7:0]  BLANK,
  output logic        STALE
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0][7:0] an_sync_r;
  logic [SYNC_STAGES-1:0][6:0] seg_sync_r;
  logic [7:0]      an_s;
  logic [6:0]      seg_s;

  seg7_state_e     state_r, state_nxt_s;
  logic [SW-1:0]   cnt_r, cnt_nxt_s;
  logic [7:0]      snap_an_r;
  logic [6:0]      snap_seg_r;
  logic            snap_load_s;
  logic            an_legal_s, same_s, capture_s, commit_s;

  logic [2:0]      pos_s;
  logic [3:0]      dec_nibble_s;
  logic            dec_hex_s, dec_blank_s;

  logic [7:0][3:0] shadow_hex_r;
  logic [7:0]      shadow_err_r, shadow_blank_r;
  logic [7:0]      seen_r, seen_nxt_s;
  logic [TW-1:0]   tmo_r, tmo_nxt_s;

  // Input synchronizer chains
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_sync_r  <= '0;
      seg_sync_r <= '0;
    end else begin
      an_sync_r  <= {an_sync_r[SYNC_STAGES-2:0], AN};
      seg_sync_r <= {seg_sync_r[SYNC_STAGES-2:0], SEG};
    end
  end

  assign an_s       = an_sync_r[SYNC_STAGES-1];
  assign seg_s      = seg_sync_r[SYNC_STAGES-1];
  assign an_legal_s = an_is_legal(an_s);
  assign same_s     = (an_s == snap_an_r) && (seg_s == snap_seg_r);
  assign capture_s  = (state_r == CAPTURE);
  assign commit_s   = (seen_r == 8'hFF);

  // Next-state logic; the count includes the sample that opened the dwell
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    snap_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (an_legal_s) begin
          snap_load_s = 1'b1;
          cnt_nxt_s   = SW'(1);
          state_nxt_s = (SETTLE_MAX == SW'(1)) ? CAPTURE : SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (same_s) begin
          cnt_nxt_s   = cnt_r + SW'(1);
          state_nxt_s = ((cnt_r + SW'(1)) >= SETTLE_MAX) ? CAPTURE : SETTLE;
        end else if (an_legal_s) begin
          snap_load_s = 1'b1;
          cnt_nxt_s   = SW'(1);
          state_nxt_s = SETTLE;
        end else begin
          cnt_nxt_s   = SW'(0);
          state_nxt_s = IDLE;
        end
      end
      CAPTURE: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (an_s != snap_an_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        cnt_nxt_s   = SW'(0);
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, settle counter and dwell snapshot
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r    <= IDLE;
      cnt_r      <= SW'(0);
      snap_an_r  <= 8'hFF;
      snap_seg_r <= 7'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (snap_load_s) begin
        snap_an_r  <= an_s;
        snap_seg_r <= seg_s;
      end else begin
        snap_an_r  <= snap_an_r;
        snap_seg_r <= snap_seg_r;
      end
    end
  end

  assign pos_s = an_position(snap_an_r);

  seg7_pattern_decode u_decode (
    .pattern  (snap_seg_r),
    .nibble   (dec_nibble_s),
    .is_hex   (dec_hex_s),
    .is_blank (dec_blank_s)
  );

  // Shadow slot update; an error keeps the previously captured nibble
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shadow_hex_r   <= '0;
      shadow_err_r   <= 8'h00;
      shadow_blank_r <= 8'h00;
    end else if (capture_s) begin
      if (dec_hex_s) begin
        shadow_hex_r[pos_s]   <= dec_nibble_s;
        shadow_err_r[pos_s]   <= 1'b0;
        shadow_blank_r[pos_s] <= 1'b0;
      end else if (dec_blank_s) begin
        shadow_hex_r[pos_s]   <= 4'h0;
        shadow_err_r[pos_s]   <= 1'b0;
        shadow_blank_r[pos_s] <= 1'b1;
      end else begin
        shadow_err_r[pos_s]   <= 1'b1;
        shadow_blank_r[pos_s] <= 1'b0;
      end
    end else begin
      shadow_hex_r   <= shadow_hex_r;
      shadow_err_r   <= shadow_err_r;
      shadow_blank_r <= shadow_blank_r;
    end
  end

  assign seen_nxt_s = (commit_s ? 8'h00 : seen_r) |
                      (capture_s ? (8'h01 << pos_s) : 8'h00);

  // Frame commit: publish the shadow set one cycle after the last position lands
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      seen_r      <= 8'h00;
      HEX         <= 32'h0;
      DIGIT_ERR   <= 8'h00;
      BLANK       <= 8'h00;
      FRAME_VALID <= 1'b0;
    end else begin
      seen_r      <= seen_nxt_s;
      FRAME_VALID <= commit_s;
      if (commit_s) begin
        HEX       <= shadow_hex_r;
        DIGIT_ERR <= shadow_err_r;
        BLANK     <= shadow_blank_r;
      end else begin
        HEX       <= HEX;
        DIGIT_ERR <= DIGIT_ERR;
        BLANK     <= BLANK;
      end
    end
  end

  assign tmo_nxt_s = (tmo_r == TIMEOUT_MAX) ? tmo_r : tmo_r + TW'(1);

  // Saturating inactivity timer; a commit cycle never raises STALE
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tmo_r <= TW'(0);
      STALE <= 1'b0;
    end else if (capture_s) begin
      tmo_r <= TW'(0);
      STALE <= 1'b0;
    end else begin
      tmo_r <= tmo_nxt_s;
      STALE <= commit_s ? STALE : (tmo_nxt_s == TIMEOUT_MAX);
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: SETTLE_CYCLES=4, TIMEOUT_CYCLES=200.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  seg = 7'd0;
  logic [31:0] hex;
  logic        frame_valid;
  logic [7:0]  digit_err;
  logic [7:0]  blank;
  logic        stale;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int fv0;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(200), .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .AN(an), .SEG(seg),
    .HEX(hex), .FRAME_VALID(frame_valid), .DIGIT_ERR(digit_err),
    .BLANK(blank), .STALE(stale)
  );

  always @(posedge clk) begin
    #1;
    if (frame_valid === 1'b1) fv_count++;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0111111;   1: return 7'b0000110;
      2: return 7'b1011011;   3: return 7'b1001111;
      4: return 7'b1100110;   5: return 7'b1101101;
      6: return 7'b1111101;   7: return 7'b0000111;
      8: return 7'b1111111;   9: return 7'b1100111;
      10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b1011000;  13: return 7'b1011110;
      14: return 7'b1111001;  15: return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic show(input int pos, input logic [6:0] s, input int dwell);
    logic [7:0] one;
    one = 8'h01;
    an  = 8'hFF ^ (one << pos);
    seg = s;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hex !== 32'h0) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex, 32'h0); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL reset_err: got %h expected 00", digit_err); end
    checks++; if (blank !== 8'h00) begin errors++; $display("FAIL reset_blank: got %h expected 00", blank); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale: got %b expected 0", stale); end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_full_scan;
    fv0 = fv_count;
    for (int p = 0; p < 8; p++) show(p, seg_of(p + 1), 10);
    idle(6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL scan_frames: got %0d expected 1", fv_count - fv0); end
    checks++; if (hex !== 32'h87654321) begin errors++; $display("FAIL scan_hex: got %h expected 87654321", hex); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL scan_err: got %h expected 00", digit_err); end
    checks++; if (blank !== 8'h00) begin errors++; $display("FAIL scan_blank: got %h expected 00", blank); end
  endtask

  task automatic test_err_blank;
    for (int p = 0; p < 8; p++) begin
      if (p == 3) show(p, 7'b0000001, 10);
      else if (p == 5) show(p, 7'b0000000, 10);
      else show(p, seg_of(15), 10);
    end
    idle(6);
    checks++; if (hex !== 32'hFF0F4FFF) begin errors++; $display("FAIL eb_hex: got %h expected FF0F4FFF", hex); end
    checks++; if (digit_err !== 8'h08) begin errors++; $display("FAIL eb_err: got %h expected 08", digit_err); end
    checks++; if (blank !== 8'h20) begin errors++; $display("FAIL eb_blank: got %h expected 20", blank); end
  endtask

  task automatic test_short_dwell;
    fv0 = fv_count;
    show(0, seg_of(0), 10);
    show(1, seg_of(1), 10);
    show(2, seg_of(2), 3);
    for (int p = 3; p < 8; p++) show(p, seg_of(p), 10);
    idle(6);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL short_noframe: got %0d expected 0", fv_count - fv0); end
    show(2, seg_of(2), 6);
    idle(6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL short_frame: got %0d expected 1", fv_count - fv0); end
    checks++; if (hex !== 32'h76543210) begin errors++; $display("FAIL short_hex: got %h expected 76543210", hex); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL short_err: got %h expected 00", digit_err); end
    checks++; if (blank !== 8'h00) begin errors++; $display("FAIL short_blank: got %h expected 00", blank); end
  endtask

  task automatic test_latency;
    fv0 = fv_count;
    for (int p = 1; p < 8; p++) show(p, seg_of(p + 8), 10);
    idle(5);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL lat_partial: got %0d expected 0", fv_count - fv0); end
    show(0, seg_of(0), 7);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0", frame_valid); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL lat_pulse: got %b expected 1", frame_valid); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got %b expected 0", frame_valid); end
    idle(5);
    checks++; if (hex !== 32'hFEDCBA90) begin errors++; $display("FAIL lat_hex: got %h expected FEDCBA90", hex); end
  endtask

  task automatic test_glitch;
    for (int p = 1; p < 8; p++) show(p, seg_of(p), 10);
    idle(5);
    show(0, seg_of(5), 3);
    seg = seg_of(8);
    @(negedge clk);
    seg = seg_of(5);
    repeat (4) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL glitch_nominal: got %b expected 0", frame_valid); end
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL glitch_early: got %b expected 0", frame_valid); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL glitch_pulse: got %b expected 1", frame_valid); end
    idle(5);
    checks++; if (hex !== 32'h76543215) begin errors++; $display("FAIL glitch_hex: got %h expected 76543215", hex); end
  endtask

  task automatic test_stale;
    idle(10);
    fv0 = fv_count;
    show(3, seg_of(2), 10);
    an = 8'hF0;
    repeat (100) @(negedge clk);
    an = 8'hFF;
    repeat (96) @(negedge clk);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_before: got %b expected 0", stale); end
    @(negedge clk);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_at_limit: got %b expected 1", stale); end
    an = 8'hF0;
    repeat (100) @(negedge clk);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_held: got %b expected 1", stale); end
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL stale_noframe: got %0d expected 0", fv_count - fv0); end
    show(4, seg_of(3), 10);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear: got %b expected 0", stale); end
  endtask

  task automatic test_reset_midframe;
    for (int p = 0; p < 5; p++) show(p, seg_of(7), 10);
    idle(3);
    rst_n = 1'b0;
    #1;
    checks++; if (hex !== 32'h0) begin errors++; $display("FAIL rmid_hex: got %h expected 0", hex); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL rmid_err: got %h expected 00", digit_err); end
    checks++; if (blank !== 8'h00) begin errors++; $display("FAIL rmid_blank: got %h expected 00", blank); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_fv: got %b expected 0", frame_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    fv0 = fv_count;
    show(5, seg_of(0), 10);
    show(6, seg_of(9), 10);
    show(7, seg_of(8), 10);
    idle(6);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL rmid_partial: got %0d expected 0", fv_count - fv0); end
    for (int p = 0; p < 5; p++) show(p, seg_of(p + 10), 10);
    idle(6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL rmid_frames: got %0d expected 1", fv_count - fv0); end
    checks++; if (hex !== 32'h890EDCBA) begin errors++; $display("FAIL rmid_hex_new: got %h expected 890EDCBA", hex); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL rmid_err_new: got %h expected 00", digit_err); end
    checks++; if (blank !== 8'h00) begin errors++; $display("FAIL rmid_blank_new: got %h expected 00", blank); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_err_blank();
    test_short_dwell();
    test_latency();
    test_glitch();
    test_stale();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
